// File: rtl/dram_cache_ctrl_pkg.sv
// Shared widths, field positions, FSM states and address/metadata helpers
// for the direct-mapped DRAM-cache controller.
package dram_cache_pkg;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 512;
    localparam int ID_W     = 16;
    localparam int TAG_W    = 16;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = 38;
    localparam int TAG_S    = 64;
    localparam int LINE_W   = DATA_W + TAG_S;

    localparam int META_VALID_BIT = LINE_W - 1;
    localparam int META_DIRTY_BIT = LINE_W - 2;
    localparam int META_TAG_HI    = LINE_W - 3;
    localparam int META_TAG_LO    = LINE_W - 2 - TAG_W;

    localparam int FILL_VALID_BIT = 47;
    localparam int FILL_DIRTY_BIT = 46;

    typedef enum logic [3:0] {
        S_IDLE,
        S_M_AR,
        S_M_R,
        S_CMP,
        S_EVICT,
        S_EVICT_B,
        S_C_AR,
        S_C_R,
        S_FILL,
        S_RESP
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [ADDR_W-1:0] set_read_addr(input logic [INDEX_W-1:0] idx);
        return {{(ADDR_W-INDEX_W){1'b0}}, idx};
    endfunction

    // DRAM fill address carries the new line's metadata alongside the set index.
    function automatic logic [ADDR_W-1:0] fill_meta_addr(input logic [TAG_W-1:0] tag,
                                                         input logic dirty,
                                                         input logic [INDEX_W-1:0] idx);
        logic [ADDR_W-1:0] m;
        m = '0;
        m[ADDR_W-1 -: TAG_W]  = tag;
        m[FILL_VALID_BIT]     = 1'b1;
        m[FILL_DIRTY_BIT]     = dirty;
        m[INDEX_W-1:0]        = idx;
        return m;
    endfunction

    function automatic logic [ADDR_W-1:0] evict_addr(input logic [TAG_W-1:0] tag,
                                                     input logic [INDEX_W-1:0] idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dram_cache_ctrl_aw_w_issuer.sv
// Issues one address beat and one data beat together; each valid drops on its
// own handshake and o_done fires in the cycle the last outstanding one completes.
module axi_aw_w_issuer
    import dram_cache_pkg::*;
#(
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_DATA_W = DATA_W,
    parameter int P_ID_W   = ID_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [P_ADDR_W-1:0] i_addr,
    input  logic [P_ID_W-1:0]   i_id,
    input  logic [P_DATA_W-1:0] i_data,
    output logic                o_awvalid,
    output logic [P_ADDR_W-1:0] o_awaddr,
    output logic [P_ID_W-1:0]   o_awid,
    input  logic                i_awready,
    output logic                o_wvalid,
    output logic [P_DATA_W-1:0] o_wdata,
    output logic [P_ID_W-1:0]   o_wid,
    input  logic                i_wready,
    output logic                o_done
);

    logic                r_awValid;
    logic [P_ADDR_W-1:0] r_awAddr;
    logic [P_ID_W-1:0]   r_id;
    logic                r_wValid;
    logic [P_DATA_W-1:0] r_wData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awValid <= 1'b0;
            r_awAddr  <= '0;
            r_id      <= '0;
            r_wValid  <= 1'b0;
            r_wData   <= '0;
        end else if (i_start) begin
            r_awValid <= 1'b1;
            r_wValid  <= 1'b1;
            r_awAddr  <= i_addr;
            r_id      <= i_id;
            r_wData   <= i_data;
        end else begin
            if (r_awValid && i_awready) r_awValid <= 1'b0;
            if (r_wValid && i_wready)   r_wValid  <= 1'b0;
        end
    end

    assign o_awvalid = r_awValid;
    assign o_awaddr  = r_awAddr;
    assign o_awid    = r_id;
    assign o_wvalid  = r_wValid;
    assign o_wdata   = r_wData;
    assign o_wid     = r_id;
    assign o_done    = (r_awValid || r_wValid) && (!r_awValid || i_awready) && (!r_wValid || i_wready);

endmodule

// File: rtl/dram_cache_ctrl.sv
// Direct-mapped DRAM-cache controller: one transaction at a time, tag lookup in
// DRAM, dirty-victim eviction and line fetch from CXL backing memory.
module dram_cache_ctrl
    import dram_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W:0]     arid_i,
    input  logic [ADDR_W:0]   araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    input  logic [ID_W:0]     awid_i,
    input  logic [ADDR_W:0]   awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic              rid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [ID_W-1:0]   m_arid_o,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    input  logic              m_rid_i,
    input  logic [LINE_W-1:0] m_rdata_i,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    output logic [ID_W-1:0]   m_awid_o,
    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [ID_W-1:0]   m_wid_o,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    output logic [ID_W-1:0]   c_arid_o,
    output logic [ADDR_W-1:0] c_araddr_o,
    output logic              c_arvalid_o,
    input  logic              c_arready_i,
    output logic [ID_W-1:0]   c_awid_o,
    output logic [ADDR_W-1:0] c_awaddr_o,
    output logic              c_awvalid_o,
    input  logic              c_awready_i,
    output logic [ID_W-1:0]   c_wid_o,
    output logic [DATA_W-1:0] c_wdata_o,
    output logic              c_wvalid_o,
    input  logic              c_wready_i,
    input  logic [ID_W-1:0]   c_rid_i,
    input  logic [DATA_W-1:0] c_rdata_i,
    input  logic              c_rvalid_i,
    output logic              c_rready_o,
    output logic [ID_W-1:0]   c_bid_o,
    output logic              c_bvalid_o,
    input  logic              c_bready_i
);

    state_t              r_state;
    logic                r_arReady;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wData;
    logic                r_isWrite;
    logic                r_vicValid;
    logic                r_vicDirty;
    logic [TAG_W-1:0]    r_vicTag;
    logic [DATA_W-1:0]   r_line;
    logic                r_mArValid;
    logic [ADDR_W-1:0]   r_mArAddr;
    logic [ID_W-1:0]     r_mArId;
    logic                r_mRReady;
    logic                r_cArValid;
    logic [ADDR_W-1:0]   r_cArAddr;
    logic [ID_W-1:0]     r_cArId;
    logic                r_cRReady;
    logic                r_cBValid;
    logic [ID_W-1:0]     r_cBId;
    logic                r_rValid;
    logic [DATA_W-1:0]   r_rData;
    logic                r_rId;

    logic                w_acceptRd;
    logic                w_acceptWr;
    logic [ID_W-1:0]     w_newId;
    logic [ADDR_W-1:0]   w_newAddr;
    logic                w_hit;
    logic                w_evict;
    logic                w_evStart;
    logic                w_evDone;
    logic                w_fillStart;
    logic                w_fillDone;
    logic [DATA_W-1:0]   w_fillData;
    logic                w_unused;

    assign w_acceptRd  = (r_state == S_IDLE) && r_arReady && arvalid_i;
    assign w_acceptWr  = (r_state == S_IDLE) && r_arReady && !arvalid_i && awvalid_i && wvalid_i;
    assign w_newId     = arvalid_i ? arid_i[ID_W-1:0] : awid_i[ID_W-1:0];
    assign w_newAddr   = arvalid_i ? araddr_i[ADDR_W-1:0] : awaddr_i[ADDR_W-1:0];

    assign w_hit       = r_vicValid && (r_vicTag == addr_tag(r_addr));
    assign w_evict     = r_vicValid && r_vicDirty && !w_hit;
    assign w_evStart   = (r_state == S_CMP) && w_evict;
    // Fill of a read miss always starts from the CXL return, so its data comes straight off c_rdata_i.
    assign w_fillStart = ((r_state == S_CMP) && r_isWrite && !w_evict)
                      || ((r_state == S_EVICT_B) && c_bready_i && r_isWrite)
                      || ((r_state == S_C_R) && c_rvalid_i);
    assign w_fillData  = r_isWrite ? r_wData : c_rdata_i;

    assign w_unused = ^{arid_i[ID_W], awid_i[ID_W], araddr_i[ADDR_W], awaddr_i[ADDR_W],
                        m_rid_i, c_rid_i, m_rdata_i[META_TAG_LO-1:DATA_W]};

    axi_aw_w_issuer u_evict (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_evStart),
        .i_addr    (evict_addr(r_vicTag, addr_index(r_addr))),
        .i_id      (r_id),
        .i_data    (r_line),
        .o_awvalid (c_awvalid_o),
        .o_awaddr  (c_awaddr_o),
        .o_awid    (c_awid_o),
        .i_awready (c_awready_i),
        .o_wvalid  (c_wvalid_o),
        .o_wdata   (c_wdata_o),
        .o_wid     (c_wid_o),
        .i_wready  (c_wready_i),
        .o_done    (w_evDone)
    );

    axi_aw_w_issuer u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_fillStart),
        .i_addr    (fill_meta_addr(addr_tag(r_addr), r_isWrite, addr_index(r_addr))),
        .i_id      (r_id),
        .i_data    (w_fillData),
        .o_awvalid (m_awvalid_o),
        .o_awaddr  (m_awaddr_o),
        .o_awid    (m_awid_o),
        .i_awready (m_awready_i),
        .o_wvalid  (m_wvalid_o),
        .o_wdata   (m_wdata_o),
        .o_wid     (m_wid_o),
        .i_wready  (m_wready_i),
        .o_done    (w_fillDone)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_arReady  <= 1'b0;
            r_id       <= '0;
            r_addr     <= '0;
            r_wData    <= '0;
            r_isWrite  <= 1'b0;
            r_vicValid <= 1'b0;
            r_vicDirty <= 1'b0;
            r_vicTag   <= '0;
            r_line     <= '0;
            r_mArValid <= 1'b0;
            r_mArAddr  <= '0;
            r_mArId    <= '0;
            r_mRReady  <= 1'b0;
            r_cArValid <= 1'b0;
            r_cArAddr  <= '0;
            r_cArId    <= '0;
            r_cRReady  <= 1'b0;
            r_cBValid  <= 1'b0;
            r_cBId     <= '0;
            r_rValid   <= 1'b0;
            r_rData    <= '0;
            r_rId      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_arReady <= 1'b1;
                    if (w_acceptRd || w_acceptWr) begin
                        r_arReady  <= 1'b0;
                        r_id       <= w_newId;
                        r_addr     <= w_newAddr;
                        r_isWrite  <= w_acceptWr;
                        if (w_acceptWr) r_wData <= wdata_i;
                        r_mArValid <= 1'b1;
                        r_mArAddr  <= set_read_addr(addr_index(w_newAddr));
                        r_mArId    <= w_newId;
                        r_state    <= S_M_AR;
                    end
                end
                S_M_AR: if (m_arready_i) begin
                    r_mArValid <= 1'b0;
                    r_mRReady  <= 1'b1;
                    r_state    <= S_M_R;
                end
                S_M_R: if (m_rvalid_i) begin
                    r_mRReady  <= 1'b0;
                    r_vicValid <= m_rdata_i[META_VALID_BIT];
                    r_vicDirty <= m_rdata_i[META_DIRTY_BIT];
                    r_vicTag   <= m_rdata_i[META_TAG_HI:META_TAG_LO];
                    r_line     <= m_rdata_i[DATA_W-1:0];
                    r_state    <= S_CMP;
                end
                S_CMP: begin
                    if (!r_isWrite && w_hit) begin
                        r_rValid <= 1'b1;
                        r_rData  <= r_line;
                        r_rId    <= r_id[0];
                        r_state  <= S_RESP;
                    end else if (w_evict) begin
                        r_state  <= S_EVICT;
                    end else if (!r_isWrite) begin
                        r_cArValid <= 1'b1;
                        r_cArAddr  <= r_addr;
                        r_cArId    <= r_id;
                        r_state    <= S_C_AR;
                    end else begin
                        r_state  <= S_FILL;
                    end
                end
                S_EVICT: if (w_evDone) begin
                    r_cBValid <= 1'b1;
                    r_cBId    <= r_id;
                    r_state   <= S_EVICT_B;
                end
                S_EVICT_B: if (c_bready_i) begin
                    r_cBValid <= 1'b0;
                    if (r_isWrite) begin
                        r_state <= S_FILL;
                    end else begin
                        r_cArValid <= 1'b1;
                        r_cArAddr  <= r_addr;
                        r_cArId    <= r_id;
                        r_state    <= S_C_AR;
                    end
                end
                S_C_AR: if (c_arready_i) begin
                    r_cArValid <= 1'b0;
                    r_cRReady  <= 1'b1;
                    r_state    <= S_C_R;
                end
                S_C_R: if (c_rvalid_i) begin
                    r_cRReady <= 1'b0;
                    r_line    <= c_rdata_i;
                    r_state   <= S_FILL;
                end
                S_FILL: if (w_fillDone) begin
                    if (r_isWrite) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rValid <= 1'b1;
                        r_rData  <= r_line;
                        r_rId    <= r_id[0];
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: if (rready_i) begin
                    r_rValid <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign arready_o   = r_arReady;
    assign awready_o   = r_arReady && !arvalid_i;
    assign wready_o    = r_arReady && !arvalid_i;
    assign rid_o       = r_rId;
    assign rdata_o     = r_rData;
    assign rvalid_o    = r_rValid;
    assign m_arid_o    = r_mArId;
    assign m_araddr_o  = r_mArAddr;
    assign m_arvalid_o = r_mArValid;
    assign m_rready_o  = r_mRReady;
    assign c_arid_o    = r_cArId;
    assign c_araddr_o  = r_cArAddr;
    assign c_arvalid_o = r_cArValid;
    assign c_rready_o  = r_cRReady;
    assign c_bid_o     = r_cBId;
    assign c_bvalid_o  = r_cBValid;

endmodule

// File: tb/tb_dram_cache_ctrl.sv
// Scoreboard-driven bench for dram_cache_ctrl: plays DRAM/CXL slaves and the
// processor, queueing expected read responses and comparing on delivery.
module tb_dram_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [16:0]  arid_i, awid_i;
    logic [64:0]  araddr_i, awaddr_i;
    logic         arvalid_i, arready_o, awvalid_i, awready_o;
    logic [511:0] wdata_i, rdata_o, m_wdata_o, c_wdata_o, c_rdata_i;
    logic         wvalid_i, wready_o, rid_o, rvalid_o, rready_i;
    logic [15:0]  m_arid_o, m_awid_o, m_wid_o, c_arid_o, c_awid_o, c_wid_o, c_rid_i, c_bid_o;
    logic [63:0]  m_araddr_o, m_awaddr_o, c_araddr_o, c_awaddr_o;
    logic         m_arvalid_o, m_arready_i, m_rid_i, m_rvalid_i, m_rready_o;
    logic [575:0] m_rdata_i;
    logic         m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
    logic         c_arvalid_o, c_arready_i, c_awvalid_o, c_awready_i, c_wvalid_o, c_wready_i;
    logic         c_rvalid_i, c_rready_o, c_bvalid_o, c_bready_i;

    int checks   = 0;
    int failures = 0;
    int cAwCount = 0;
    int cArCount = 0;
    int mAwCount = 0;

    logic [511:0] expRdata[$];
    logic         expRid[$];

    localparam logic [63:0] ADDR_A = 64'habcd1234abcd1234;

    always #5 clk = ~clk;

    dram_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wid_o(m_wid_o), .m_wdata_o(m_wdata_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .c_arid_o(c_arid_o), .c_araddr_o(c_araddr_o), .c_arvalid_o(c_arvalid_o), .c_arready_i(c_arready_i),
        .c_awid_o(c_awid_o), .c_awaddr_o(c_awaddr_o), .c_awvalid_o(c_awvalid_o), .c_awready_i(c_awready_i),
        .c_wid_o(c_wid_o), .c_wdata_o(c_wdata_o), .c_wvalid_o(c_wvalid_o), .c_wready_i(c_wready_i),
        .c_rid_i(c_rid_i), .c_rdata_i(c_rdata_i), .c_rvalid_i(c_rvalid_i), .c_rready_o(c_rready_o),
        .c_bid_o(c_bid_o), .c_bvalid_o(c_bvalid_o), .c_bready_i(c_bready_i)
    );

    // Handshake-start counters let tests prove a channel was never used.
    always @(posedge clk) begin
        if (c_awvalid_o && c_awready_i) cAwCount++;
        if (c_arvalid_o) cArCount++;
        if (m_awvalid_o) mAwCount++;
    end

    function automatic logic [575:0] mk_line(input logic v, input logic d, input logic [15:0] t,
                                             input logic [511:0] data);
        mk_line = {v, d, t, 46'd0, data};
    endfunction

    task automatic drive_read(input logic [63:0] a, input logic [15:0] id);
        while (arready_o !== 1'b1) @(negedge clk);
        arvalid_i = 1'b1; araddr_i = {1'b1, a}; arid_i = {1'b1, id};
        @(negedge clk);
        arvalid_i = 1'b0;
    endtask

    task automatic drive_write(input logic [63:0] a, input logic [511:0] d, input logic [15:0] id);
        while (awready_o !== 1'b1) @(negedge clk);
        awvalid_i = 1'b1; wvalid_i = 1'b1; awaddr_i = {1'b0, a}; wdata_i = d; awid_i = {1'b0, id};
        @(negedge clk);
        awvalid_i = 1'b0; wvalid_i = 1'b0;
    endtask

    task automatic serve_m_ar(output logic [63:0] a, output logic [15:0] id);
        while (m_arvalid_o !== 1'b1) @(negedge clk);
        a = m_araddr_o; id = m_arid_o;
        m_arready_i = 1'b1;
        @(negedge clk);
        m_arready_i = 1'b0;
    endtask

    task automatic serve_m_r(input logic [575:0] line);
        while (m_rready_o !== 1'b1) @(negedge clk);
        m_rvalid_i = 1'b1; m_rdata_i = line;
        @(negedge clk);
        m_rvalid_i = 1'b0;
    endtask

    task automatic serve_c_ar(output logic [63:0] a);
        while (c_arvalid_o !== 1'b1) @(negedge clk);
        a = c_araddr_o;
        c_arready_i = 1'b1;
        @(negedge clk);
        c_arready_i = 1'b0;
    endtask

    task automatic serve_c_r(input logic [511:0] d);
        while (c_rready_o !== 1'b1) @(negedge clk);
        c_rvalid_i = 1'b1; c_rdata_i = d;
        @(negedge clk);
        c_rvalid_i = 1'b0;
    endtask

    task automatic serve_fill(output logic [63:0] a, output logic [511:0] d);
        while (m_awvalid_o !== 1'b1) @(negedge clk);
        a = m_awaddr_o; d = m_wdata_o;
        m_awready_i = 1'b1; m_wready_i = 1'b1;
        @(negedge clk);
        m_awready_i = 1'b0; m_wready_i = 1'b0;
    endtask

    task automatic serve_evict(output logic [63:0] a, output logic [511:0] d, output logic [15:0] bid);
        while (c_awvalid_o !== 1'b1) @(negedge clk);
        a = c_awaddr_o; d = c_wdata_o;
        c_awready_i = 1'b1; c_wready_i = 1'b1;
        @(negedge clk);
        c_awready_i = 1'b0; c_wready_i = 1'b0;
        while (c_bvalid_o !== 1'b1) @(negedge clk);
        bid = c_bid_o;
        c_bready_i = 1'b1;
        @(negedge clk);
        c_bready_i = 1'b0;
    endtask

    task automatic take_resp(output logic [511:0] d, output logic rid);
        while (rvalid_o !== 1'b1) @(negedge clk);
        d = rdata_o; rid = rid_o;
        rready_i = 1'b1;
        @(negedge clk);
        rready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (arready_o !== 1'b0 || m_arvalid_o !== 1'b0 || rvalid_o !== 1'b0 || c_awvalid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got arready=%b m_arvalid=%b rvalid=%b c_awvalid=%b required all 0",
                     arready_o, m_arvalid_o, rvalid_o, c_awvalid_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (arready_o !== 1'b1 || awready_o !== 1'b1 || wready_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_ready: got ar=%b aw=%b w=%b required 1 1 1", arready_o, awready_o, wready_o);
        end
    endtask

    task automatic pop_and_compare(input logic [511:0] d, input logic rid);
        logic [511:0] ed;
        logic         er;
        checks++;
        if (expRdata.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: got unexpected response %h required none", d);
        end else begin
            ed = expRdata.pop_front();
            er = expRid.pop_front();
            if (d !== ed || rid !== er) begin
                failures++;
                $display("[TB] FAIL rdata: got %h rid %b required %h rid %b", d, rid, ed, er);
            end
        end
    endtask

    task automatic test_read_miss_invalid();
        logic [63:0]  a;
        logic [15:0]  id;
        logic [511:0] d;
        logic         rid;
        int           cAwBefore;
        cAwBefore = cAwCount;
        expRdata.push_back(512'habcabcabc); expRid.push_back(1'b1);
        drive_read(ADDR_A, 16'h0003);
        serve_m_ar(a, id);
        checks++;
        if (a !== 64'h48 || id !== 16'h0003) begin
            failures++;
            $display("[TB] FAIL miss_m_araddr: got %h id %h required %h id %h", a, id, 64'h48, 16'h0003);
        end
        serve_m_r(mk_line(1'b0, 1'b0, 16'h0, 512'h0));
        serve_c_ar(a);
        checks++;
        if (a !== ADDR_A) begin
            failures++;
            $display("[TB] FAIL miss_c_araddr: got %h required %h", a, ADDR_A);
        end
        serve_c_r(512'habcabcabc);
        serve_fill(a, d);
        checks++;
        if (a !== 64'habcd800000000048 || d !== 512'habcabcabc) begin
            failures++;
            $display("[TB] FAIL miss_fill: got addr %h data %h required %h %h", a, d, 64'habcd800000000048, 512'habcabcabc);
        end
        take_resp(d, rid);
        pop_and_compare(d, rid);
        checks++;
        if (cAwCount !== cAwBefore) begin
            failures++;
            $display("[TB] FAIL miss_no_evict: got %0d evictions required 0", cAwCount - cAwBefore);
        end
    endtask

    task automatic test_read_hit();
        logic [63:0]  a;
        logic [15:0]  id;
        logic [511:0] d;
        logic         rid;
        int           cArBefore, mAwBefore;
        cArBefore = cArCount; mAwBefore = mAwCount;
        expRdata.push_back(512'h1234); expRid.push_back(1'b0);
        drive_read(ADDR_A, 16'h0010);
        serve_m_ar(a, id);
        serve_m_r(mk_line(1'b1, 1'b0, 16'habcd, 512'h1234));
        take_resp(d, rid);
        pop_and_compare(d, rid);
        checks++;
        if (cArCount !== cArBefore || mAwCount !== mAwBefore) begin
            failures++;
            $display("[TB] FAIL hit_no_traffic: got c_ar %0d fill %0d cycles required 0 0",
                     cArCount - cArBefore, mAwCount - mAwBefore);
        end
    endtask

    task automatic test_read_miss_dirty();
        logic [63:0]  a;
        logic [15:0]  id;
        logic [511:0] d;
        logic         rid;
        expRdata.push_back(512'h777); expRid.push_back(1'b1);
        drive_read(ADDR_A, 16'h0021);
        serve_m_ar(a, id);
        serve_m_r(mk_line(1'b1, 1'b1, 16'hffff, 512'hdead));
        serve_evict(a, d, id);
        checks++;
        if (a !== 64'hffff120000000000 || d !== 512'hdead || id !== 16'h0021) begin
            failures++;
            $display("[TB] FAIL evict: got addr %h data %h bid %h required %h %h %h",
                     a, d, id, 64'hffff120000000000, 512'hdead, 16'h0021);
        end
        serve_c_ar(a);
        checks++;
        if (a !== ADDR_A) begin
            failures++;
            $display("[TB] FAIL dirty_c_araddr: got %h required %h", a, ADDR_A);
        end
        serve_c_r(512'h777);
        serve_fill(a, d);
        checks++;
        if (a !== 64'habcd800000000048 || d !== 512'h777) begin
            failures++;
            $display("[TB] FAIL dirty_fill: got addr %h data %h required %h %h", a, d, 64'habcd800000000048, 512'h777);
        end
        take_resp(d, rid);
        pop_and_compare(d, rid);
    endtask

    task automatic test_write_miss();
        logic [63:0]  a;
        logic [15:0]  id;
        logic [511:0] d;
        int           cArBefore;
        cArBefore = cArCount;
        drive_write(64'h0001000000000000, 512'h55, 16'h0005);
        serve_m_ar(a, id);
        checks++;
        if (a !== 64'h0 || id !== 16'h0005) begin
            failures++;
            $display("[TB] FAIL write_m_araddr: got %h id %h required 0 id 0005", a, id);
        end
        serve_m_r(mk_line(1'b1, 1'b0, 16'h2222, 512'h99));
        serve_fill(a, d);
        checks++;
        if (a !== 64'h0001c00000000000 || a[47:46] !== 2'b11 || d !== 512'h55) begin
            failures++;
            $display("[TB] FAIL write_fill: got addr %h data %h required %h %h", a, d, 64'h0001c00000000000, 512'h55);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (arready_o !== 1'b1 || rvalid_o !== 1'b0 || cArCount !== cArBefore) begin
            failures++;
            $display("[TB] FAIL write_done: got arready=%b rvalid=%b c_ar=%0d required 1 0 0",
                     arready_o, rvalid_o, cArCount - cArBefore);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]  a;
        logic [511:0] d;
        logic         rid;
        expRdata.push_back(512'hbeef); expRid.push_back(1'b1);
        drive_read(ADDR_A, 16'h0007);
        while (m_arvalid_o !== 1'b1) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (m_arvalid_o !== 1'b1 || m_araddr_o !== 64'h48) begin
                failures++;
                $display("[TB] FAIL bp_m_ar: got valid %b addr %h required 1 %h", m_arvalid_o, m_araddr_o, 64'h48);
            end
        end
        m_arready_i = 1'b1;
        @(negedge clk);
        m_arready_i = 1'b0;
        serve_m_r(mk_line(1'b0, 1'b0, 16'h0, 512'h0));
        while (c_arvalid_o !== 1'b1) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (c_arvalid_o !== 1'b1 || c_araddr_o !== ADDR_A) begin
                failures++;
                $display("[TB] FAIL bp_c_ar: got valid %b addr %h required 1 %h", c_arvalid_o, c_araddr_o, ADDR_A);
            end
        end
        serve_c_ar(a);
        serve_c_r(512'hbeef);
        while (m_awvalid_o !== 1'b1) @(negedge clk);
        m_awready_i = 1'b1;
        @(negedge clk);
        m_awready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_awvalid_o !== 1'b0 || m_wvalid_o !== 1'b1 || m_wdata_o !== 512'hbeef) begin
                failures++;
                $display("[TB] FAIL bp_fill_w: got awvalid %b wvalid %b data %h required 0 1 %h",
                         m_awvalid_o, m_wvalid_o, m_wdata_o, 512'hbeef);
            end
            @(negedge clk);
        end
        m_wready_i = 1'b1;
        @(negedge clk);
        m_wready_i = 1'b0;
        while (rvalid_o !== 1'b1) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid_o !== 1'b1 || rdata_o !== 512'hbeef) begin
                failures++;
                $display("[TB] FAIL bp_resp: got rvalid %b data %h required 1 %h", rvalid_o, rdata_o, 512'hbeef);
            end
        end
        take_resp(d, rid);
        pop_and_compare(d, rid);
    endtask

    task automatic test_reset_mid();
        logic [63:0]  a;
        logic [15:0]  id;
        logic [511:0] d;
        logic         rid;
        drive_read(64'h1111000000000000, 16'h0002);
        serve_m_ar(a, id);
        serve_m_r(mk_line(1'b0, 1'b0, 16'h0, 512'h0));
        serve_c_ar(a);
        while (c_rready_o !== 1'b1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({c_rready_o, m_arvalid_o, m_awvalid_o, m_wvalid_o, c_arvalid_o, c_awvalid_o, c_wvalid_o,
             c_bvalid_o, rvalid_o, m_rready_o} !== 10'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_valids: got c_rready=%b m_ar=%b m_aw=%b c_ar=%b rvalid=%b required all 0",
                     c_rready_o, m_arvalid_o, m_awvalid_o, c_arvalid_o, rvalid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (arready_o !== 1'b1 || c_rready_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset_release: got arready=%b c_rready=%b required 1 0", arready_o, c_rready_o);
        end
        expRdata.push_back(512'h42); expRid.push_back(1'b0);
        drive_read(64'h1111000000000000, 16'h0004);
        serve_m_ar(a, id);
        serve_m_r(mk_line(1'b1, 1'b0, 16'h1111, 512'h42));
        take_resp(d, rid);
        pop_and_compare(d, rid);
    endtask

    initial begin
        arid_i = '0; araddr_i = '0; arvalid_i = 1'b0;
        awid_i = '0; awaddr_i = '0; awvalid_i = 1'b0;
        wdata_i = '0; wvalid_i = 1'b0; rready_i = 1'b0;
        m_arready_i = 1'b0; m_rid_i = 1'b0; m_rdata_i = '0; m_rvalid_i = 1'b0;
        m_awready_i = 1'b0; m_wready_i = 1'b0;
        c_arready_i = 1'b0; c_awready_i = 1'b0; c_wready_i = 1'b0;
        c_rid_i = '0; c_rdata_i = '0; c_rvalid_i = 1'b0; c_bready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_read_miss_invalid();
        test_read_hit();
        test_read_miss_dirty();
        test_write_miss();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (expRdata.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending required 0", expRdata.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout at %0t required completion", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
